program_loader: RTL and testbench

- Writer-side counterpart to the instruction ROM: a boot loader that fills a writable program memory from a byte stream.
- Receives a length-prefixed image over a valid/ready byte interface and assembles big-endian 32-bit instruction words.
- Issues one write per word using the same byte-address convention as the fetch path (word index = Address[DATA_WIDTH-1:2]).
- Sits between the host/UART byte source and the program RAM write port; the processor is held off while Busy=1.

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader_byte_word_assembler.sv | 34 +++
 rtl/program_loader.sv | 192 +++++++++++++++++++
 tb/tb_program_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
package program_loader_pkg;

    localparam int unsigned LEN_WIDTH         = 16;
    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned BYTE_WIDTH        = 8;
    localparam int unsigned WORD_WIDTH        = BYTES_PER_WORD * BYTE_WIDTH;
    localparam int unsigned CNT_WIDTH         = $clog2(BYTES_PER_WORD);
    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h0040_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // States in which the loader accepts stream bytes.
    function automatic logic takes_bytes(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/program_loader_byte_word_assembler.sv
// Shifts stream bytes MSB-first into a word; flags the byte that completes it.
module byte_word_assembler
    import program_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [WORD_WIDTH-1:0] word_c,
    output logic                  word_ready_c
);

    localparam int unsigned HOLD_WIDTH = WORD_WIDTH - BYTE_WIDTH;

    logic [HOLD_WIDTH-1:0] shift_q;
    logic [CNT_WIDTH-1:0]  count_q;

    // Word as it stands once the current byte is appended.
    assign word_c       = {shift_q, byte_in};
    assign word_ready_c = byte_en && (count_q == CNT_WIDTH'(BYTES_PER_WORD - 1));

    // Shift register and byte counter; the counter wraps after each full word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (byte_en) begin
            shift_q <= word_c[HOLD_WIDTH-1:0];
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: fills program RAM from a length-prefixed, big-endian byte stream.
// Optional trailing XOR checksum enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] ADDR_BASE    = DATA_WIDTH'(ADDR_BASE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [LEN_WIDTH-1:0]  WordCount
);

    state_t                state_q, state_d;
    logic                  ready_d, memwrite_d, busy_d, done_d, error_d;
    logic [DATA_WIDTH-1:0] address_d, wdata_d;
    logic [LEN_WIDTH-1:0]  wordcount_d, length_q, length_d, index_q, index_d;
    logic [LEN_WIDTH-1:0]  len_rx_c;
    logic                  byte_acc_c, asm_clear_c, asm_en_c, word_ready_c;
    logic [WORD_WIDTH-1:0] word_c;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] chk_q, chk_d;
`endif

    assign byte_acc_c = ByteValid && ByteReady;
    assign asm_en_c   = byte_acc_c && (state_q == ST_DATA);
    assign len_rx_c   = {length_q[LEN_WIDTH-1:BYTE_WIDTH], ByteIn};

    byte_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear        (asm_clear_c),
        .byte_en      (asm_en_c),
        .byte_in      (ByteIn),
        .word_c       (word_c),
        .word_ready_c (word_ready_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        memwrite_d  = 1'b0;
        address_d   = Address;
        wdata_d     = WriteData;
        busy_d      = Busy;
        done_d      = Done;
        error_d     = Error;
        wordcount_d = WordCount;
        length_d    = length_q;
        index_d     = index_q;
        asm_clear_c = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk_d       = byte_acc_c ? (chk_q ^ ByteIn) : chk_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d     = ST_LEN_HI;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    wordcount_d = '0;
                    length_d    = '0;
                    index_d     = '0;
                    asm_clear_c = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    chk_d       = '0;
`endif
                end
            end
            ST_LEN_HI: begin
                if (byte_acc_c) begin
                    length_d = {ByteIn, BYTE_WIDTH'(0)};
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byte_acc_c) begin
                    length_d = len_rx_c;
                    if (len_rx_c == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else if (len_rx_c > LEN_WIDTH'(MEMORY_DEPTH)) begin
                        state_d = ST_ERROR;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_ready_c) begin
                    state_d    = ST_WRITE;
                    memwrite_d = 1'b1;
                    address_d  = ADDR_BASE + DATA_WIDTH'({index_q, CNT_WIDTH'(0)});
                    wdata_d    = DATA_WIDTH'(word_c);
                end
            end
            ST_WRITE: begin
                index_d     = index_q + LEN_WIDTH'(1);
                wordcount_d = WordCount + LEN_WIDTH'(1);
                if ((index_q + LEN_WIDTH'(1)) == length_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (byte_acc_c) begin
                    busy_d = 1'b0;
                    if ((chk_q ^ ByteIn) == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = takes_bytes(state_d);
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ByteReady <= 1'b0;
            MemWrite  <= 1'b0;
            Address   <= '0;
            WriteData <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            WordCount <= '0;
            length_q  <= '0;
            index_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            ByteReady <= ready_d;
            MemWrite  <= memwrite_d;
            Address   <= address_d;
            WriteData <= wdata_d;
            Busy      <= busy_d;
            Done      <= done_d;
            Error     <= error_d;
            WordCount <= wordcount_d;
            length_q  <= length_d;
            index_q   <= index_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table of loads plus a scoreboard of RAM writes.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset, start, ByteValid;
    logic [7:0]  ByteIn;
    logic        ByteReady, MemWrite, Busy, Done, Error;
    logic [31:0] Address, WriteData;
    logic [15:0] WordCount;

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          gaps;
        bit          chk_flip;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    program_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .WordCount (WordCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] word_at(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return v.w0 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (MemWrite) begin
            logic [63:0] e;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got %h/%h expected no write", Address, WriteData);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", Address, e[63:32]);
                check("write_data", WriteData, e[31:0]);
            end
            check("ready_in_write", 32'(ByteReady), 32'd0);
        end
    end

    // Present one byte, wait (bounded) until it is accepted; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            ByteValid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        ByteValid = 1'b1;
        ByteIn    = b;
        t = 0;
        while (!ByteReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ByteReady) begin
            n_total++;
            $display("FAIL byte_timeout: got ready=0 expected ready=1 for byte %h", b);
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(Busy), 32'd0);
        check({tag, "_done"},  32'(Done), 32'd0);
        check({tag, "_error"}, 32'(Error), 32'd0);
        check({tag, "_ready"}, 32'(ByteReady), 32'd0);
        check({tag, "_mw"},    32'(MemWrite), 32'd0);
        check({tag, "_addr"},  Address, 32'd0);
        check({tag, "_wdata"}, WriteData, 32'd0);
        check({tag, "_wc"},    32'(WordCount), 32'd0);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_busy"},  32'(Busy), 32'd1);
        check({tag, "_start_ready"}, 32'(ByteReady), 32'd1);
        check({tag, "_start_done"},  32'(Done), 32'd0);
        check({tag, "_start_err"},   32'(Error), 32'd0);
        check({tag, "_start_wc"},    32'(WordCount), 32'd0);
    endtask

    // One complete load: start, length, words (if legal), optional checksum, then final status.
    task automatic run_load(input vec_t v, input string tag);
        logic [7:0]  x;
        logic [31:0] w;
        int          t;
        bit          legal;
        legal = (v.n <= 16'd32);
        pulse_start(tag);
        if (legal) begin
            for (int i = 0; i < int'(v.n); i++)
                exp_q.push_back({32'h0040_0000 + 32'(i) * 32'd4, word_at(v, i)});
        end
        x = v.n[15:8] ^ v.n[7:0];
        send_byte(v.n[15:8], v.gaps ? int'($urandom_range(0, 3)) : 0);
        send_byte(v.n[7:0],  v.gaps ? int'($urandom_range(0, 3)) : 0);
        if (legal) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = word_at(v, i);
                for (int k = 0; k < 4; k++) begin
                    x ^= 8'(w >> (24 - 8 * k));
                    send_byte(8'(w >> (24 - 8 * k)), v.gaps ? int'($urandom_range(0, 3)) : 0);
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            send_byte(x ^ {7'd0, v.chk_flip}, v.gaps ? int'($urandom_range(0, 3)) : 0);
`endif
        end
        ByteValid = 1'b0;
        t = 0;
        while (Busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_busy_end"},  32'(Busy), 32'd0);
        check({tag, "_done"},      32'(Done), 32'(v.exp_done));
        check({tag, "_error"},     32'(Error), 32'(v.exp_err));
        check({tag, "_wc"},        32'(WordCount), 32'(v.exp_wc));
        check({tag, "_ready_end"}, 32'(ByteReady), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0] = '{16'd2,  32'h2008_0005, 32'h0109_5020, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
        vecs[1] = '{16'd0,  32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[2] = '{16'd33, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[3] = '{16'd2,  32'h2008_0005, 32'h0109_5020, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
        vecs[4] = '{16'd32, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 16'd32};
        vecs[5] = '{16'd1,  32'hA5A5_0F0F, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 16'd1};

        reset = 1'b1; start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_load(vecs[i], $sformatf("vec%0d", i));

        // Reset after two bytes of the second word: the first word is written, nothing more.
        pulse_start("midreset");
        exp_q.push_back({32'h0040_0000, 32'h2008_0005});
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_byte(8'h01, 0); send_byte(8'h09, 0);
        ByteValid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        check("midreset_writes_left", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        run_load(vecs[0], "reload");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        v = vecs[0];
        v.chk_flip = 1'b1;
        v.exp_done = 1'b0;
        v.exp_err  = 1'b1;
        run_load(v, "bad_chk");
`else
        v = vecs[0];
`endif
        run_load(v, "final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
